// File: rtl/hilo_muldiv_unit.sv
// HI/LO result register with its own radix-2 iterative multiplier and optional restoring divider.
// Define HILO_DIV_EN to build the divider datapath and the DIVU/DIV ops.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             stateQ, stateD;
  logic [WIDTH-1:0]   hiQ, loQ, magA, magB, absA, absB;
  logic [2*WIDTH-1:0] acc, iterNext, prodFix;
  logic [WIDTH:0]     addSum;
  logic [CNT_W-1:0]   countQ;
  logic               negResult, skipQ, doneQ, startSkip;

`ifdef HILO_DIV_EN
  logic             isDiv, negRem, dbzQ;
  logic [WIDTH:0]   remTrial, diff;
  logic [WIDTH-1:0] quotFix, remFix;

  assign startSkip = op[1] && (src_b == '0);
`else
  // Without the divider a divide op just bounces through FIN without touching HI/LO.
  assign startSkip = op[1];
`endif

  always_comb begin
    absA = (op[0] && src_a[WIDTH-1]) ? ('0 - src_a) : src_a;
    absB = (op[0] && src_b[WIDTH-1]) ? ('0 - src_b) : src_b;
  end

  always_ff @(posedge clk) begin
    if (!reset) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (start) stateD = startSkip ? FIN : RUN;
      RUN:     if (countQ == CNT_W'(1)) stateD = FIN;
      FIN:     stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    addSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? magA : '0)};
    iterNext = {addSum, acc[WIDTH-1:1]};
    prodFix  = negResult ? ('0 - acc) : acc;
`ifdef HILO_DIV_EN
    remTrial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = remTrial - {1'b0, magB};
    if (isDiv)
      iterNext = diff[WIDTH] ? {remTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                             : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    quotFix  = negResult ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    remFix   = negRem ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hiQ       <= '0;
      loQ       <= '0;
      magA      <= '0;
      magB      <= '0;
      acc       <= '0;
      countQ    <= '0;
      negResult <= 1'b0;
      skipQ     <= 1'b0;
      doneQ     <= 1'b0;
`ifdef HILO_DIV_EN
      isDiv     <= 1'b0;
      negRem    <= 1'b0;
      dbzQ      <= 1'b0;
`endif
    end else begin
      doneQ <= 1'b0;
`ifdef HILO_DIV_EN
      dbzQ  <= 1'b0;
`endif
      case (stateQ)
        IDLE: begin
          if (mthi) hiQ <= wdata;
          if (mtlo) loQ <= wdata;
          if (start) begin
            magA      <= absA;
            magB      <= absB;
            acc       <= op[1] ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
            countQ    <= CNT_W'(WIDTH);
            negResult <= op[0] && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            skipQ     <= startSkip;
`ifdef HILO_DIV_EN
            isDiv     <= op[1];
            negRem    <= op[0] && src_a[WIDTH-1];
`endif
          end
        end
        RUN: begin
          acc    <= iterNext;
          countQ <= countQ - 1'b1;
        end
        FIN: begin
          doneQ <= 1'b1;
`ifdef HILO_DIV_EN
          dbzQ  <= skipQ;
          if (!skipQ) begin
            if (isDiv) begin
              hiQ <= remFix;
              loQ <= quotFix;
            end else begin
              hiQ <= prodFix[2*WIDTH-1:WIDTH];
              loQ <= prodFix[WIDTH-1:0];
            end
          end
`else
          if (!skipQ) begin
            hiQ <= prodFix[2*WIDTH-1:WIDTH];
            loQ <= prodFix[WIDTH-1:0];
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy   = (stateQ != IDLE);
  assign done   = doneQ;
  assign hi_out = hiQ;
  assign lo_out = loQ;
`ifdef HILO_DIV_EN
  assign div_by_zero = dbzQ;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: expected HI/LO results are queued at start and popped at done.
// Divide expectations follow HILO_DIV_EN, matching the RTL build.
module tb_hilo_muldiv_unit;
  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              reset, start, mthi, mtlo;
  logic [1:0]        op;
  logic [WIDTH-1:0]  srcA, srcB, wdata;
  logic              busy, done, divByZero;
  logic [WIDTH-1:0]  hiOut, loOut;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dbz;
    int               lat;
  } exp_t;

  exp_t             sbQ[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic [WIDTH-1:0] modelHi = '0;
  logic [WIDTH-1:0] modelLo = '0;

  hilo_muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(srcA), .src_b(srcB), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(divByZero),
    .hi_out(hiOut), .lo_out(loOut)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t        e;
    longint      pa, pb;
    logic [63:0] p;
    e.hi  = modelHi;
    e.lo  = modelLo;
    e.dbz = 1'b0;
    e.lat = WIDTH + 1;
    if (!o[1]) begin
      pa = o[0] ? longint'(signed'(a)) : longint'({32'b0, a});
      pb = o[0] ? longint'(signed'(b)) : longint'({32'b0, b});
      p  = pa * pb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else begin
`ifdef HILO_DIV_EN
      if (b == '0) begin
        e.dbz = 1'b1;
        e.lat = 1;
      end else if (o[0]) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000;
          e.hi = '0;
        end else begin
          int qa, qb;
          qa = signed'(a);
          qb = signed'(b);
          e.lo = 32'(qa / qb);
          e.hi = 32'(qa % qb);
        end
      end else begin
        e.lo = a / b;
        e.hi = a % b;
      end
`else
      e.lat = 1;
`endif
    end
    return e;
  endfunction

  // Called on a falling edge; returns on the falling edge right after the accepting edge E0.
  task automatic applyStimulus(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    sbQ.push_back(model(o, a, b));
    op    = o;
    srcA  = a;
    srcB  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic interfere);
    exp_t e;
    int   k = 0;
    logic busyOk = 1'b1;
    e = sbQ.pop_front();
    if (e.lat > 1) compare({tag, "/busyE0"}, busy, 1);
    while (!done && k < 200) begin
      if (interfere && k == 3) begin
        mtlo  = 1'b1;
        wdata = 32'hDEAD_BEEF;
        start = 1'b1;
        op    = 2'b00;
        srcA  = 32'd1;
        srcB  = 32'd1;
      end else begin
        mtlo  = 1'b0;
        start = 1'b0;
      end
      if (!busy) busyOk = 1'b0;
      @(negedge clk);
      k++;
    end
    mtlo  = 1'b0;
    start = 1'b0;
    compare({tag, "/latency"}, k, e.lat);
    if (e.lat > 1) compare({tag, "/busyHeld"}, busyOk, 1);
    compare({tag, "/busyAtDone"}, busy, 0);
    compare({tag, "/hi"}, hiOut, e.hi);
    compare({tag, "/lo"}, loOut, e.lo);
    compare({tag, "/dbz"}, divByZero, e.dbz);
    modelHi = e.hi;
    modelLo = e.lo;
    @(negedge clk);
    compare({tag, "/donePulse"}, done, 0);
  endtask

  task automatic watchNoDone(input string tag, input int n);
    logic saw = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    compare(tag, saw, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; srcA = '0; srcB = '0; wdata = '0;
    repeat (2) @(negedge clk);
    compare("reset/hi", hiOut, 0);
    compare("reset/lo", loOut, 0);
    compare("reset/busy", busy, 0);
    compare("reset/done", done, 0);
    reset = 1'b1;
    @(negedge clk);

    mthi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    compare("mthi/hi", hiOut, 32'h1234_5678);
    compare("mthi/lo", loOut, 0);
    mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    mtlo = 1'b0;
    compare("mtlo/lo", loOut, 32'hCAFE_F00D);
    modelHi = 32'h1234_5678;
    modelLo = 32'hCAFE_F00D;

    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    compare("multuMax/hiHeld", hiOut, 32'h1234_5678);
    checkOutput("multuMax", 1'b0);
    compare("multuMax/hiConst", hiOut, 32'hFFFF_FFFE);
    compare("multuMax/loConst", loOut, 32'h0000_0001);

    applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000);
    checkOutput("multMinSq", 1'b0);
    applyStimulus(2'b01, 32'hFFFF_FFFD, 32'd7);
    checkOutput("multNeg3x7", 1'b0);
    compare("multNeg3x7/loConst", loOut, 32'hFFFF_FFEB);

    applyStimulus(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    checkOutput("multuInterfere", 1'b1);
    watchNoDone("multuInterfere/singleDone", 40);

    mthi = 1'b1; wdata = 32'h55AA_55AA;
    applyStimulus(2'b01, 32'd5, 32'hFFFF_FFFE);
    mthi = 1'b0;
    compare("mthiWithStart/hi", hiOut, 32'h55AA_55AA);
    checkOutput("mult5xNeg2", 1'b0);

    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2);
    checkOutput("divNeg7by2", 1'b0);
    applyStimulus(2'b10, 32'd100, 32'd0);
    checkOutput("divuBy0", 1'b0);
    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("divMinByNeg1", 1'b0);
    applyStimulus(2'b10, 32'd100, 32'd7);
    checkOutput("divu100by7", 1'b0);
    applyStimulus(2'b01, 32'd3, 32'hFFFF_FFFF);
    checkOutput("mult3xNeg1", 1'b0);

    applyStimulus(2'b00, 32'd3, 32'd5);
    void'(sbQ.pop_back());
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compare("abort/hi", hiOut, 0);
    compare("abort/lo", loOut, 0);
    compare("abort/busy", busy, 0);
    reset = 1'b1;
    watchNoDone("abort/noDone", 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
